// File: rtl/sum_accumulator.sv
// sum_accumulator: sums NUM_SAMPLES accepted inputs with saturation and presents the frame total on a valid/ready port
module sum_accumulator #(
  parameter int IN_W = 5,
  parameter int ACC_W = 10,
  parameter int NUM_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             acc_sat,
  output logic             busy
);
  localparam int CNT_W = $clog2(NUM_SAMPLES) + 1;
  localparam logic [ACC_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic sat, sat_nx;
  logic [ACC_W:0] sum_wide;
  logic ovf, accept, done;
  assign sum_ready = state != HOLD;
  assign acc_valid = state == HOLD;
  assign busy = state != IDLE;
  assign accept = sum_valid && sum_ready;
  assign sum_wide = {1'b0, acc} + (ACC_W + 1)'(sum_in);
  assign ovf = sum_wide[ACC_W];
  // next state and next accumulator contents; done marks the accept that completes a frame
  always_comb begin
    state_nx = state;
    acc_nx = acc;
    cnt_nx = cnt;
    sat_nx = sat;
    done = 1'b0;
    case (state)
      IDLE: if (accept) begin
        acc_nx = ACC_W'(sum_in);
        cnt_nx = CNT_W'(1);
        sat_nx = 1'b0;
        done = NUM_SAMPLES == 1;
        state_nx = done ? HOLD : ACCUM;
      end
      ACCUM: if (accept) begin
        acc_nx = ovf ? MAX : sum_wide[ACC_W-1:0];
        cnt_nx = cnt + 1'b1;
        sat_nx = sat | ovf;
        done = cnt == LAST;
        state_nx = done ? HOLD : ACCUM;
      end
      HOLD: if (acc_ready) begin
        acc_nx = '0;
        cnt_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // accumulator, count and the result registers captured when a frame completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
      acc_out <= '0;
      acc_sat <= 1'b0;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      sat <= sat_nx;
      if (done) begin
        acc_out <= acc_nx;
        acc_sat <= sat_nx;
      end
    end
endmodule
